// File: rtl/selector_2_pkg.sv
// Shared select encoding for the 4-to-1 selector.
// Select codes map one-to-one to sources A..D.
// No state, no flow control.
package selector_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/selector_2_if.sv
// Selector bus: select, four sources, combinational and registered result.
// master drives select/data, slave returns out/out_q.
// No handshake; data is sampled every cycle.
interface selector_2_if #(
  parameter int WIDTH = 1
);
  import selector_pkg::*;

  sel_t             sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  modport master (
    output sel, A, B, C, D,
    input  out, out_q
  );

  modport slave (
    input  sel, A, B, C, D,
    output out, out_q
  );

endinterface

// File: rtl/selector_2_mux4.sv
// Pure 4-to-1 mux leaf.
// Latency: 0 cycles (combinational).
// No backpressure; output follows inputs continuously.
module selector_2_mux4
  import selector_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);

  // Every 2-valued code has its own arm; the up-front default only keeps synthesis latch-free.
  always_comb begin
    y = '0;
    case (sel)
      SEL_A: y = a;
      SEL_B: y = b;
      SEL_C: y = c;
      SEL_D: y = d;
    endcase
  end

endmodule

// File: rtl/selector_2.sv
// 4-to-1 selector with combinational out and registered out_q.
// Latency: out 0 cycles, out_q 1 cycle; rst clears out_q only.
// No backpressure; inputs are consumed every cycle.
module selector_2
  import selector_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  selector_2_if.slave  bus
);

  logic [WIDTH-1:0] mux_dat;
  logic [WIDTH-1:0] out_q_r;

  selector_2_mux4 #(
    .WIDTH (WIDTH)
  ) u_mux4 (
    .sel (bus.sel),
    .a   (bus.A),
    .b   (bus.B),
    .c   (bus.C),
    .d   (bus.D),
    .y   (mux_dat)
  );

  assign bus.out = mux_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q_r <= '0;
    end else begin
      out_q_r <= mux_dat;
    end
  end

  assign bus.out_q = out_q_r;

endmodule

// File: tb/tb_selector_2.sv
// Scoreboard bench for selector_2 at WIDTH=1 and WIDTH=8.
module tb_selector_2;
  import selector_pkg::*;

  logic clk;
  logic rst;

  selector_2_if #(.WIDTH(1)) if1 ();
  selector_2_if #(.WIDTH(8)) if8 ();

  selector_2 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  selector_2 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  int checks   = 0;
  int failures = 0;

  logic [31:0] qc  [$];
  logic [31:0] qr1 [$];
  logic [31:0] qr8 [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick(input sel_t s, input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] src [4];
    src = '{a, b, c, d};
    return src[s];
  endfunction

  // Registered-path scoreboard: expectation taken from inputs present at the edge.
  always @(posedge clk) begin
    qr1.push_back(rst ? 32'd0 : {24'd0, pick(if1.sel, {7'd0, if1.A}, {7'd0, if1.B},
                                              {7'd0, if1.C}, {7'd0, if1.D})});
    qr8.push_back(rst ? 32'd0 : {24'd0, pick(if8.sel, if8.A, if8.B, if8.C, if8.D)});
    #1;
    check("out_q_w1", {31'd0, if1.out_q}, qr1.pop_front());
    check("out_q_w8", {24'd0, if8.out_q}, qr8.pop_front());
  end

  task automatic apply1(input sel_t s, input logic a, input logic b, input logic c, input logic d);
    if1.sel = s;
    if1.A = a;
    if1.B = b;
    if1.C = c;
    if1.D = d;
    qc.push_back({24'd0, pick(s, {7'd0, a}, {7'd0, b}, {7'd0, c}, {7'd0, d})});
    #1;
    check("out_w1", {31'd0, if1.out}, qc.pop_front());
    #9;
  endtask

  task automatic apply8(input sel_t s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    if8.sel = s;
    if8.A = a;
    if8.B = b;
    if8.C = c;
    if8.D = d;
    qc.push_back({24'd0, pick(s, a, b, c, d)});
    #1;
    check("out_w8", {24'd0, if8.out}, qc.pop_front());
    #9;
  endtask

  initial begin
    rst = 1'b1;
    if1.sel = SEL_A; if1.A = 1'b0; if1.B = 1'b0; if1.C = 1'b0; if1.D = 1'b0;
    if8.sel = SEL_A; if8.A = 8'h00; if8.B = 8'h00; if8.C = 8'h00; if8.D = 8'h00;

    // Two edges in reset with out=1: out_q must stay 0.
    apply1(SEL_B, 1'b0, 1'b1, 1'b0, 1'b0);
    apply1(SEL_B, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    apply1(SEL_B, 1'b0, 1'b1, 1'b0, 1'b0);
    apply1(SEL_A, 1'b0, 1'b1, 1'b0, 1'b0);

    // One-hot walk for every select value.
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 4; h++) begin
        apply1(sel_t'(s), h == 0, h == 1, h == 2, h == 3);
      end
    end

    // Reset asserted between edges: out_q holds until the edge, out never moves.
    #2;
    rst = 1'b1;
    #1;
    check("rst_hold_out_q", {31'd0, if1.out_q}, 32'd1);
    check("rst_hold_out", {31'd0, if1.out}, 32'd1);
    #7;
    check("rst_clear_out_q", {31'd0, if1.out_q}, 32'd0);
    check("rst_keep_out", {31'd0, if1.out}, 32'd1);
    apply1(SEL_D, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    apply1(SEL_D, 1'b0, 1'b0, 1'b0, 1'b1);

    // All-zero sources.
    for (int s = 0; s < 4; s++) begin
      apply1(sel_t'(s), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    apply1(SEL_A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Select and data change in the same timestep.
    apply1(SEL_D, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("simul_out_q", {31'd0, if1.out_q}, 32'd1);
    #9;

    // Wide datapath patterns.
    for (int s = 0; s < 4; s++) begin
      apply8(sel_t'(s), 8'h11, 8'h22, 8'h44, 8'h88);
    end
    for (int i = 0; i < 8; i++) begin
      apply8(sel_t'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom));
    end

    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
